// File: rtl/shift_register_n_if.sv
// Bus bundle for shift_register_n: load/shift requests toward the register,
// contents and status back from it.
//
// Handshake: ld and start are level requests sampled on a rising clk edge
// while the block is idle (ld wins over start). After start, busy is high
// for one cycle per step; done pulses for exactly one cycle at completion.
// No backpressure exists; requests seen while busy or done are ignored.
interface shift_register_n_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic [WIDTH-1:0]   D;
  logic               ld;
  logic               start;
  logic [2:0]         mode;
  logic [SHAMT_W-1:0] amt;
  logic               sin;
  logic [WIDTH-1:0]   Q;
  logic               busy;
  logic               done;
  logic               sout;

  modport master (
    output D, ld, start, mode, amt, sin,
    input  Q, busy, done, sout
  );

  modport slave (
    input  D, ld, start, mode, amt, sin,
    output Q, busy, done, sout
  );
endinterface

// File: rtl/shift_register_n.sv
// Multi-cycle shift/rotate register. A start request runs amt single-bit
// steps of the latched mode, one per clock, then a one-cycle done pulse.
module shift_register_n #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  shift_register_n_if.slave   bus,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t             state_q;
  logic [WIDTH-1:0]   q_q;
  logic               sout_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [2:0]         mode_q;

  logic [WIDTH-1:0]   q_d;
  logic               sout_d;

  // One single-bit step of the latched mode; undefined modes hold Q and sout.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    case (mode_q)
      3'b000: begin
        q_d    = {q_q[WIDTH-2:0], bus.sin};
        sout_d = q_q[WIDTH-1];
      end
      3'b001: begin
        q_d    = {bus.sin, q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      3'b010: begin
        q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      3'b011: begin
        q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        sout_d = q_q[WIDTH-1];
      end
      3'b100: begin
        q_d    = {q_q[0], q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      default: begin
        q_d    = q_q;
        sout_d = sout_q;
      end
    endcase
  end

  // Control FSM with data path; reset overrides any request in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ld) begin
            q_q <= bus.D;
          end else if (bus.start) begin
            mode_q  <= bus.mode;
            cnt_q   <= bus.amt;
            state_q <= (bus.amt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          q_q    <= q_d;
          sout_q <= sout_d;
          cnt_q  <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Q    = q_q;
  assign bus.sout = sout_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign state_o  = state_q;

endmodule

// File: tb/tb_shift_register_n.sv
// Directed bench for shift_register_n (WIDTH=8, SHAMT_W=3).
module tb_shift_register_n;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;
  int         n_checks;
  int         n_pass;
  logic [7:0] exp_q[$];

  shift_register_n_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  shift_register_n #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic load(input logic [7:0] d);
    bus.ld = 1'b1;
    bus.D  = d;
    tick();
    bus.ld = 1'b0;
    check("load_q", bus.Q, d);
    check("load_busy", bus.busy, 1'b0);
  endtask

  // Runs one operation; expected Q per step comes from exp_q.
  task automatic run_op(input logic [2:0] m, input logic [2:0] a, input logic s);
    logic [7:0] e;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.amt   = a;
    bus.sin   = s;
    tick();
    bus.start = 1'b0;
    if (a == 3'd0) begin
      check("amt0_busy", bus.busy, 1'b0);
      check("amt0_done", bus.done, 1'b1);
    end else begin
      check("start_busy", bus.busy, 1'b1);
      check("start_done", bus.done, 1'b0);
      for (int i = 0; i < int'(a); i++) begin
        tick();
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 32'd1, 32'd0);
          e = bus.Q;
        end else begin
          e = exp_q.pop_front();
        end
        check("step_q", bus.Q, e);
        check("step_busy", bus.busy, i < int'(a) - 1);
        check("step_done", bus.done, i == int'(a) - 1);
      end
    end
    tick();
    check("end_done", bus.done, 1'b0);
    check("end_busy", bus.busy, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    bus.D     = '0;
    bus.ld    = 1'b0;
    bus.start = 1'b0;
    bus.mode  = '0;
    bus.amt   = '0;
    bus.sin   = 1'b0;

    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_q", bus.Q, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_sout", bus.sout, 1'b0);
    check("rst_state", state_o, 2'd0);

    // load AA, SHL x3 sin=0
    load(8'hAA);
    exp_q.push_back(8'h54); exp_q.push_back(8'hA8); exp_q.push_back(8'h50);
    run_op(3'b000, 3'd3, 1'b0);
    check("shl_sout", bus.sout, 1'b1);

    // SHR logical x2 with sin=1 on 50
    exp_q.push_back(8'hA8); exp_q.push_back(8'hD4);
    run_op(3'b001, 3'd2, 1'b1);
    check("shr_sout", bus.sout, 1'b0);

    // SAR x2 on 81
    load(8'h81);
    exp_q.push_back(8'hC0); exp_q.push_back(8'hE0);
    run_op(3'b010, 3'd2, 1'b1);
    check("sar_sout", bus.sout, 1'b0);

    // ROR x1 on 01
    load(8'h01);
    exp_q.push_back(8'h80);
    run_op(3'b100, 3'd1, 1'b0);
    check("ror_sout", bus.sout, 1'b1);

    // sout held across a parallel load
    load(8'h3C);
    check("ld_sout_hold", bus.sout, 1'b1);

    // ROL x3 on 3C
    exp_q.push_back(8'h78); exp_q.push_back(8'hF0); exp_q.push_back(8'hE1);
    run_op(3'b011, 3'd3, 1'b0);
    check("rol_sout", bus.sout, 1'b1);

    // SAR maximum amount saturates to sign
    load(8'h80);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'hFF);
    exp_q[0] = 8'hC0; exp_q[1] = 8'hE0; exp_q[2] = 8'hF0;
    exp_q[3] = 8'hF8; exp_q[4] = 8'hFC; exp_q[5] = 8'hFE;
    run_op(3'b010, 3'd7, 1'b0);
    check("sar7_sout", bus.sout, 1'b0);

    // undefined mode holds Q and sout
    load(8'h5A);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
    run_op(3'b101, 3'd2, 1'b1);
    check("mode5_sout", bus.sout, 1'b0);

    // zero amount
    run_op(3'b000, 3'd0, 1'b1);
    check("amt0_q", bus.Q, 8'h5A);

    // ld and start together: load only
    bus.ld = 1'b1; bus.D = 8'h33; bus.start = 1'b1; bus.mode = 3'b000; bus.amt = 3'd2;
    tick();
    bus.ld = 1'b0; bus.start = 1'b0;
    check("prio_q", bus.Q, 8'h33);
    check("prio_busy", bus.busy, 1'b0);
    tick();
    check("prio_busy2", bus.busy, 1'b0);
    check("prio_done", bus.done, 1'b0);
    check("prio_q2", bus.Q, 8'h33);

    // ld during SHIFT ignored (SHL x2 sin=1 on 33)
    bus.start = 1'b1; bus.mode = 3'b000; bus.amt = 3'd2; bus.sin = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ld = 1'b1; bus.D = 8'hFF;
    tick();
    check("ign_q1", bus.Q, 8'h67);
    tick();
    bus.ld = 1'b0;
    check("ign_q2", bus.Q, 8'hCF);
    check("ign_done", bus.done, 1'b1);
    tick();
    check("ign_q3", bus.Q, 8'hCF);

    // reset in the second SHIFT cycle of amt=5
    load(8'h0F);
    bus.start = 1'b1; bus.mode = 3'b000; bus.amt = 3'd5; bus.sin = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("mid_q1", bus.Q, 8'h1F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_q", bus.Q, 8'h00);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_sout", bus.sout, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("mid_no_done", bus.done, 1'b0);
      tick();
    end

    // new operation after reset
    load(8'h03);
    exp_q.push_back(8'h06); exp_q.push_back(8'h0C);
    run_op(3'b011, 3'd2, 1'b0);
    check("post_sout", bus.sout, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
